// File: rtl/axo_debug_i2c_bridge_pkg.sv
// Shared types and constants for the debug I2C bridge.
package axo_debug_pkg;

    // Bridge FSM states. The encoding is visible on the debug state port.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } axo_state_e;

    // Value of the R/W bit that follows the 7-bit address.
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    localparam logic [6:0] AXO_DEFAULT_SLAVE_ADDR = 7'h52;

endpackage

// File: rtl/axo_i2c_filter.sv
// Synchroniser plus debounce for one I2C pad line. The filtered level only
// follows the synchronised line after DEBOUNCE+1 consecutive differing cycles;
// rise/fall pulses are high for the single cycle in which the level changes.
module axo_i2c_filter #(
    parameter int TBITS    = 8,
    parameter int DEBOUNCE = 63
) (
    input  logic clock,
    input  logic reset_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic [TBITS-1:0] cnt_q;

    // Two-flop synchroniser; idle bus level is high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level once it has differed for DEBOUNCE+1 cycles; any return restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == TBITS'(DEBOUNCE)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                rise_q  <= sync2_q;
                fall_q  <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + TBITS'(1);
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/axo_debug_i2c_bridge.sv
// I2C slave bridging a debug probe onto the xrd_* debug register bus.
// Bus strobes: xrd_re / xrd_we are single-cycle pulses qualified by nothing
// else; xrd_addr and xrd_wdata are valid in the strobe cycle, xrd_rdata is
// expected in the cycle after xrd_re. The pointer advances after each strobe.
module axo_debug_i2c_bridge
    import axo_debug_pkg::*;
#(
    parameter int         TBITS      = 8,
    parameter int         DEBOUNCE   = 63,
    parameter int         TIMEOUT    = 255,
    parameter logic [6:0] SLAVE_ADDR = AXO_DEFAULT_SLAVE_ADDR,
    parameter int         ABYTES     = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sda_in,
    input  logic                  scl_in,
    output logic                  sda_pulldown_en,
    output logic [8*ABYTES-1:0]   xrd_addr,
    output logic [7:0]            xrd_wdata,
    input  logic [7:0]            xrd_rdata,
    output logic                  xrd_re,
    output logic                  xrd_we,
    input  logic                  xrd_present,
    output logic                  busy,
    output axo_state_e            dbg_state_o
);

    localparam int PW = 8 * ABYTES;

    logic sda_f, sda_rise, sda_fall;
    logic scl_f, scl_rise, scl_fall;

    axo_i2c_filter #(.TBITS(TBITS), .DEBOUNCE(DEBOUNCE)) u_sda_filter (
        .clock(clock), .reset_n(reset_n), .line_i(sda_in),
        .level_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    axo_i2c_filter #(.TBITS(TBITS), .DEBOUNCE(DEBOUNCE)) u_scl_filter (
        .clock(clock), .reset_n(reset_n), .line_i(scl_in),
        .level_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    axo_state_e       state_q;
    logic [2:0]       bitcnt_q;
    logic [7:0]       shift_q;
    logic [PW-1:0]    ptr_q;
    logic [2:0]       ptr_cnt_q;
    logic             rw_q;
    logic             ack_ph_q;   // 0: waiting for the fall that opens the ACK slot, 1: slot open
    logic             ack_ok_q;
    logic             mack_q;
    logic             sda_oe_q;
    logic             xrd_re_q;
    logic             xrd_we_q;
    logic             rd_lat_q;
    logic [7:0]       wdata_q;
    logic [7:0]       tx_q;
    logic             busy_q;
    logic [TBITS-1:0] tmo_q;

    logic       start_ev;
    logic       stop_ev;
    logic       tmo_hit;
    logic [7:0] rx_byte_d;

    assign start_ev  = sda_fall & scl_f;
    assign stop_ev   = sda_rise & scl_f;
    assign rx_byte_d = {shift_q[6:0], sda_f};
    assign tmo_hit   = (TIMEOUT != 0) && busy_q && !scl_f && (tmo_q == TBITS'(TIMEOUT - 1));

    // Count consecutive filtered SCL-low cycles while addressed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (!busy_q || scl_f || tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TBITS'(1);
        end
    end

    // Protocol FSM with bus strobes, pointer and SDA drive.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            ptr_cnt_q <= '0;
            rw_q      <= I2C_WRITE;
            ack_ph_q  <= 1'b0;
            ack_ok_q  <= 1'b0;
            mack_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            xrd_re_q  <= 1'b0;
            xrd_we_q  <= 1'b0;
            rd_lat_q  <= 1'b0;
            wdata_q   <= '0;
            tx_q      <= 8'hFF;
            busy_q    <= 1'b0;
        end else begin
            xrd_re_q <= 1'b0;
            xrd_we_q <= 1'b0;
            rd_lat_q <= xrd_re_q;
            if (xrd_re_q || xrd_we_q) ptr_q <= ptr_q + PW'(1);
            if (rd_lat_q) tx_q <= xrd_present ? xrd_rdata : 8'hFF;

            if (stop_ev || tmo_hit) begin
                state_q  <= ST_IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (start_ev) begin
                state_q  <= ST_ADDR;
                bitcnt_q <= '0;
                sda_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        if (scl_rise) begin
                            shift_q  <= rx_byte_d;
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                ack_ph_q <= 1'b0;
                                case (state_q)
                                    ST_ADDR: begin
                                        if (rx_byte_d[7:1] == SLAVE_ADDR) begin
                                            state_q   <= ST_ADDR_ACK;
                                            busy_q    <= 1'b1;
                                            rw_q      <= rx_byte_d[0];
                                            ack_ok_q  <= 1'b1;
                                            ptr_cnt_q <= '0;
                                            if (rx_byte_d[0] == I2C_READ) xrd_re_q <= 1'b1;
                                        end else begin
                                            state_q <= ST_IGNORE;
                                            busy_q  <= 1'b0;
                                        end
                                    end
                                    ST_PTR: begin
                                        ptr_q     <= (ptr_q << 8) | PW'(rx_byte_d);
                                        ptr_cnt_q <= ptr_cnt_q + 3'd1;
                                        ack_ok_q  <= 1'b1;
                                        state_q   <= ST_PTR_ACK;
                                    end
                                    default: begin
                                        state_q  <= ST_WDATA_ACK;
                                        ack_ok_q <= xrd_present;
                                        if (xrd_present) begin
                                            xrd_we_q <= 1'b1;
                                            wdata_q  <= rx_byte_d;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_ph_q) begin
                                ack_ph_q <= 1'b1;
                                sda_oe_q <= ack_ok_q;
                            end else begin
                                ack_ph_q <= 1'b0;
                                bitcnt_q <= '0;
                                sda_oe_q <= 1'b0;
                                if (state_q == ST_ADDR_ACK && rw_q == I2C_READ) begin
                                    state_q  <= ST_RDATA;
                                    sda_oe_q <= ~tx_q[7];
                                end else if (state_q == ST_ADDR_ACK ||
                                             (state_q == ST_PTR_ACK && ptr_cnt_q != 3'(ABYTES))) begin
                                    state_q <= ST_PTR;
                                end else begin
                                    state_q <= ST_WDATA;
                                end
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                state_q  <= ST_RDATA_ACK;
                                ack_ph_q <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            tx_q     <= {tx_q[6:0], 1'b1};
                            sda_oe_q <= ~tx_q[6];
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_fall && !ack_ph_q) begin
                            ack_ph_q <= 1'b1;
                            sda_oe_q <= 1'b0;
                        end else if (scl_rise && ack_ph_q) begin
                            mack_q <= ~sda_f;
                            if (!sda_f) xrd_re_q <= 1'b1;
                        end else if (scl_fall && ack_ph_q) begin
                            ack_ph_q <= 1'b0;
                            bitcnt_q <= '0;
                            if (mack_q) begin
                                state_q  <= ST_RDATA;
                                sda_oe_q <= ~tx_q[7];
                            end else begin
                                state_q <= ST_IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_pulldown_en = sda_oe_q;
    assign xrd_addr        = ptr_q;
    assign xrd_wdata       = wdata_q;
    assign xrd_re          = xrd_re_q;
    assign xrd_we          = xrd_we_q;
    assign busy            = busy_q;
    assign dbg_state_o     = state_q;

endmodule

// File: doc/axo_debug_i2c_bridge.md
Name: axo_debug_i2c_bridge

Overview:
Parametrised I²C slave that bridges an external debug probe onto the core debug register bus (xrd_*). It debounces SDA/SCL in the core clock domain and detects START, repeated-START and STOP. It decodes a 7-bit slave address and a multi-byte register pointer, then issues byte-wide debug reads and writes with pointer auto-increment. It sits between the chip I²C pads and the debug unit, and supersedes the fixed-width debug I²C front end.

Parameters:
TBITS, 8, width of the debounce and timeout counters.
DEBOUNCE, 63, cycles a synchronised line must be stable before its level is accepted; must be < 2^TBITS.
TIMEOUT, 255, cycles SCL may stay low inside a transfer before the FSM aborts to IDLE; 0 disables the timeout.
SLAVE_ADDR, 7'h52, 7-bit I²C address.
ABYTES, 2, register pointer bytes sent MSB first; pointer width is 8*ABYTES, and 1..4 are legal.

Ports:
clock  in  1  ungated core clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
sda_in  in  1  raw SDA pad input.
scl_in  in  1  raw SCL pad input.
sda_pulldown_en  out  1  1 = drive SDA low (open drain).
xrd_addr  out  8*ABYTES  debug register address = current pointer.
xrd_wdata  out  8  write data.
xrd_rdata  in  8  read data; valid in the cycle after xrd_re.
xrd_re  out  1  single-cycle read strobe.
xrd_we  out  1  single-cycle write strobe.
xrd_present  in  1  selected HART present; if 0, data bytes are NACKed.
busy  out  1  1 while addressed (ADDR_ACK through STOP/abort).

Behaviour:
- Reset: the FSM goes to IDLE. sda_pulldown_en=0, xrd_re=0, xrd_we=0, xrd_addr=0, xrd_wdata=0, busy=0. Filtered SDA/SCL reset to 1.
- Input path: a 2-flop synchroniser per line, then the debounce counter. The filtered level changes only after DEBOUNCE+1 consecutive cycles of a differing synced value. Any glitch restarts the counter.
- Events, evaluated on filtered lines:
  - START: SDA 1→0 while SCL=1.
  - STOP: SDA 0→1 while SCL=1.
  - Data is sampled on the SCL rising edge.
  - SDA is changed only on the SCL falling edge, including the ACK drive and release.
- START in any state, including mid-byte, resets the bit counter and goes to ADDR. STOP in any state goes to IDLE and releases SDA.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - ADDR: shift 8 bits. On a match with SLAVE_ADDR, go to ADDR_ACK and drive ACK. On a mismatch, go to IGNORE with SDA undriven.
  - Write direction (R/W=0): the next ABYTES bytes load the pointer MSB first, each ACKed. Subsequent bytes go to WDATA.
  - WDATA: after the 8th bit, if xrd_present=1, pulse xrd_we for one cycle with the current pointer and byte, then ACK. Otherwise NACK and do not write. The pointer increments after each write.
  - Read direction (R/W=1): after ADDR_ACK, pulse xrd_re. Latch xrd_rdata the next cycle, before the SCL falling edge that ends ACK. Shift it out MSB first. The pointer increments after each read strobe.
  - RDATA_ACK: master ACK → prefetch the next byte the same way. Master NACK → go to IGNORE and release SDA.
  - In read direction with xrd_present=0, send 8'hFF.
- Pointer wraps modulo 2^(8*ABYTES). It persists across transactions until reset, so a repeated START with R=1 reads from the last written pointer.
- Timeout: when busy and SCL is held low for TIMEOUT consecutive cycles, go to IDLE and release SDA. A STOP is not required to recover.
- Simultaneous START/STOP and SCL-edge detection in the same cycle: START/STOP wins and no bit is shifted.
- No strobe is issued on a partial byte. Reset mid-write suppresses any pending xrd_we.

Decomposition:
- Shared package axo_debug_pkg: FSM state enum, I²C R/W bit constants, default SLAVE_ADDR.
- Sub-module axo_i2c_filter, instantiated twice (SDA, SCL): synchroniser plus DEBOUNCE counter, outputs the filtered level and rise/fall pulses.

Test Plan:
- Write 0x52/W, ptr 0x12,0x34, data 0xAB,0xCD, STOP → xrd_we pulses at addr 0x1234 (0xAB) and 0x1235 (0xCD); all 5 bytes ACKed.
- Write ptr 0x00FF, repeated START, 0x52/R, read 2 bytes, NACK last → xrd_re at 0x00FF and 0x0100; SDA carries xrd_rdata MSB first.
- Address 0x53 → no ACK, no strobes, SDA never driven until the next START.
- SDA glitch 10 cycles wide (DEBOUNCE=63) while SCL high → no START/STOP detected; FSM state unchanged.
- SCL held low 300 cycles mid-byte (TIMEOUT=255) → busy=0 by cycle 256, SDA released; a subsequent clean write succeeds.
- xrd_present=0 during a write data byte → NACK, no xrd_we; pointer 0xFFFF after a read → wraps to 0x0000.
